// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nsa_pkg;

  // Width of one datapath slice.
  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble counter width; never below one bit so a single-nibble build still has a counter.
  function automatic int unsigned idx_w(input int unsigned nib);
    return ($clog2(nib) > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// Four-bit ripple-carry adder slice built from a chain of full adders.
module ripple_carry_adder_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder: one 4-bit ripple slice reused over WIDTH/4 cycles,
// LSB nibble first, with the inter-nibble carry registered.
// Optional build macro NSA_OVERFLOW_FLAG_EN adds the out_ovf signed-overflow output.
module nibble_serial_add_ctrl
  import nsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef NSA_OVERFLOW_FLAG_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = idx_w(NIB);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a non-zero multiple of 4");
  end

  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a, r_b, r_sum;
  logic               r_cout;

  logic               w_accept, w_last;
  logic [WIDTH-1:0]   w_a_shift, w_b_shift;
  logic [NIB_W-1:0]   w_slice_sum;
  logic               w_slice_cout;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_last    = (r_idx == IDX_W'(NIB - 1));
  // Bring the active nibble down to bit 0 so the slice always sees bits [3:0].
  assign w_a_shift = r_a >> (r_idx * NIB_W);
  assign w_b_shift = r_b >> (r_idx * NIB_W);

  ripple_carry_adder_4bit u_slice (
    .i_a    (w_a_shift[NIB_W-1:0]),
    .i_b    (w_b_shift[NIB_W-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)           w_state_next = RUN;
      RUN:     if (w_last)             w_state_next = DONE;
      DONE:    if (out_ready)          w_state_next = IDLE;
      default:                         w_state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state == RUN) || (r_state == DONE);
  end

  // Operand capture, nibble stepping and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= in_b;
      r_carry <= in_cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_idx*NIB_W +: NIB_W] <= w_slice_sum;
      r_carry                     <= w_slice_cout;
      if (w_last) begin
        r_idx  <= '0;
        r_cout <= w_slice_cout;
      end else begin
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

  assign out_sum  = r_sum;
  assign out_cout = r_cout;

`ifdef NSA_OVERFLOW_FLAG_EN
  logic r_ovf;

  // Signed overflow: like-signed operands whose sum flips sign; captured on the top nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_slice_sum[NIB_W-1] != r_a[WIDTH-1]);
    end
  end

  assign out_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16): directed vectors with literal
// expectations plus randomized traffic, all checked against a transaction-level model.
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
`ifdef NSA_OVERFLOW_FLAG_EN
  logic             out_ovf;
`endif

  int total = 0;
  int bad   = 0;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef NSA_OVERFLOW_FLAG_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one operation in flight, result ready NIB edges after accept.
  bit               m_active = 0;
  int               m_age    = 0;
  bit               m_virgin = 1;
  logic [WIDTH:0]   m_res    = '0;
  logic             m_ovf    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      m_age    = 0;
      m_virgin = 1;
    end else if (m_active) begin
      if (m_age >= NIB && out_ready) m_active = 0;
      else if (m_age < NIB)          m_age++;
    end else if (in_valid) begin
      m_active = 1;
      m_age    = 0;
      m_virgin = 0;
      m_res    = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
      m_ovf    = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (m_res[WIDTH-1] != in_a[WIDTH-1]);
    end
  end

  // Compare DUT against model every cycle, away from the rising edge.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(!m_active));
    chk("busy", 32'(busy), 32'(m_active));
    chk("out_valid", 32'(out_valid), 32'(m_active && m_age >= NIB));
    if (m_active && m_age >= NIB) begin
      chk("out_sum", 32'(out_sum), 32'(m_res[WIDTH-1:0]));
      chk("out_cout", 32'(out_cout), 32'(m_res[WIDTH]));
`ifdef NSA_OVERFLOW_FLAG_EN
      chk("out_ovf", 32'(out_ovf), 32'(m_ovf));
`endif
    end else if (m_virgin) begin
      chk("reset_sum", 32'(out_sum), 32'h0);
      chk("reset_cout", 32'(out_cout), 32'h0);
`ifdef NSA_OVERFLOW_FLAG_EN
      chk("reset_ovf", 32'(out_ovf), 32'h0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE, check latency and literal result, apply bp cycles of stall.
  task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                    input logic [WIDTH-1:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                    input int bp);
    int lat;
    logic [WIDTH-1:0] held_sum;
    logic held_cout;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(NIB));
    chk("lit_sum", 32'(out_sum), 32'(exp_sum));
    chk("lit_cout", 32'(out_cout), 32'(exp_cout));
`ifdef NSA_OVERFLOW_FLAG_EN
    chk("lit_ovf", 32'(out_ovf), 32'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
    held_sum  = out_sum;
    held_cout = out_cout;
    for (int i = 0; i < bp; i++) begin
      in_valid = i[0];
      in_a     = WIDTH'($urandom);
      tick();
      chk("bp_sum_stable", 32'(out_sum), 32'(held_sum));
      chk("bp_cout_stable", 32'(out_cout), 32'(held_cout));
      chk("bp_in_ready", 32'(in_ready), 32'h0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after_hs", 32'(in_ready), 32'h1);
    chk("no_valid_after_hs", 32'(out_valid), 32'h0);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    tick();

    op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
    op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0);
    op(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 6);
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    op(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0);
    op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

    // Abort mid-RUN (idx=2) with a one-cycle reset.
    in_a = 16'hFFFF; in_b = 16'h0001; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'h1);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_out_valid", 32'(out_valid), 32'h0);
    chk("abort_sum", 32'(out_sum), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NIB + 2; i++) tick();
    op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

    // Random traffic; the model and compare process check every cycle.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = WIDTH'($urandom);
      in_b      = WIDTH'($urandom);
      in_cin    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NIB + 3; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencing controller that performs WIDTH-bit additions on one shared 4-bit ripple-carry adder slice (ripple_carry_adder_4bit), one nibble per clock, LSB nibble first.
- Inter-nibble carry is held in a register and fed back into the slice's cin.
- Accepts operands over a valid/ready input handshake and returns the sum over a valid/ready output handshake.
- Sits in front of the adder datapath as its only driver; it trades area for latency.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and >= 4. Elaboration error otherwise.
- NIB (localparam), WIDTH/4, number of nibble steps per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  controller can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in to nibble 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  sum.
- out_cout  output  1  carry-out of the MSB nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- FSM states:
  - IDLE: in_ready=1.
  - RUN: nibble counter idx runs 0..NIB-1.
  - DONE: out_valid=1.
- Reset (async assert, sync deassert handled upstream): state=IDLE, idx=0, carry reg=0, operand regs=0, out_sum=0, out_cout=0, out_valid=0, in_ready=1, busy=0.
- Input accept: in_valid && in_ready on edge T. This latches in_a, in_b, and carry<=in_cin, sets idx<=0, and moves to RUN.
- RUN, each edge:
  - The slice is driven with a=A[4*idx+:4], b=B[4*idx+:4], cin=carry.
  - Slice sum is written to sum_reg[4*idx+:4]; carry<=slice cout; idx<=idx+1.
  - On the edge that writes idx=NIB-1: out_cout<=slice cout, state<=DONE, idx wraps to 0.
- Latency: out_valid rises exactly NIB cycles after the accept edge (4 cycles for WIDTH=16).
- DONE:
  - out_sum and out_cout are held stable while out_valid=1 and out_ready=0; unlimited backpressure is allowed.
  - An out_valid && out_ready edge moves to IDLE. The next accept is possible on the following cycle at the earliest; there is no same-cycle turnaround.
- in_ready=0 in RUN and DONE. in_valid in those states is ignored, and in_a/in_b changes do not affect the operation in flight.
- out_sum is registered and changes only on RUN edges; its value is not meaningful outside DONE.
- Arithmetic: result = in_a + in_b + in_cin, modulo 2^WIDTH, with out_cout the (WIDTH+1)th bit. No truncation warnings; all intermediate slices are exactly 4 bits.
- Reset mid-RUN or mid-DONE aborts the operation immediately. No out_valid is produced, and outputs return to reset values.
- Slice combinational path is one ripple adder only; carry is registered between nibbles, so there is no multi-nibble combinational chain.

Optional Feature:
- Macro: NSA_OVERFLOW_FLAG_EN.
- Defined: adds output port out_ovf (1 bit, reset 0).
  - Set on the final RUN edge to signed two's-complement overflow: (A[WIDTH-1]==B[WIDTH-1]) && (sum MSB != A[WIDTH-1]).
  - Held with out_sum in DONE.
- Not defined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package nsa_pkg:
  - state enum {IDLE, RUN, DONE} (2-bit encoding).
  - Constant NIB_W=4.
  - Function clog2-based IDX_W(NIB) = max(1, $clog2(NIB)).
- Sub-module: instantiate the existing ripple_carry_adder_4bit once as the datapath slice. No other sub-modules; FSM, counter and registers are inline.

Test Plan:
- WIDTH=16: in_a=0x0000, in_b=0x0000, cin=0 -> out_valid 4 cycles after accept, out_sum=0x0000, out_cout=0.
- in_a=0xFFFF, in_b=0x0001, cin=0 -> carry propagates through all nibbles, out_sum=0x0000, out_cout=1. Then 0xFFFF+0xFFFF cin=1 -> 0xFFFF, cout=1.
- in_a=0x1234, in_b=0x4321, cin=1 -> out_sum=0x5556, out_cout=0. in_a=0xA5A5, in_b=0x5A5A, cin=0 -> 0xFFFF, cout=0.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid, toggle in_valid/in_a meanwhile -> out_sum/out_cout stable, in_ready=0, no new accept. Release -> IDLE next cycle, in_ready=1.
- Assert rst_n=0 at RUN idx=2 for 1 cycle -> all outputs at reset values, no out_valid. A fresh request of 0x0F0F+0x00F1 -> 0x1000, cout=0.
- With NSA_OVERFLOW_FLAG_EN: 0x7FFF+0x0001 -> out_ovf=1, out_sum=0x8000. 0x8000+0xFFFF -> out_ovf=1, out_sum=0x7FFF, cout=1. 0x0001+0x0001 -> out_ovf=0.
